multicycle_ctrl: RTL and testbench

- Moore-style main control FSM that sequences the shared-ALU, single-memory datapath as a MIPS-subset multicycle processor.
- Takes the opcode from the instruction register and drives every mux select and write enable in the datapath: PC, memory, IR, register file and ALU.
- Adds a memory wait-state handshake, a global stall, an illegal-opcode flag and a retired-instruction counter.

---
 rtl/multicycle_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// Main control FSM for a multicycle MIPS-subset datapath (shared ALU, single memory).
// Moore decode of state, with memory wait states, global stall, illegal-opcode flag and retire counter.
module multicycle_ctrl #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             mem_ready,
  input  logic [5:0]       op,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             iord,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             mem_to_reg,
  output logic             reg_dst,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       pc_src,
  output logic [3:0]       state,
  output logic             illegal,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    ALUWB  = 4'd7,
    BRANCH = 4'd8,
    JUMP   = 4'd9,
    ADDIEX = 4'd10,
    ADDIWB = 4'd11
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  state_t           r_state;
  state_t           w_next;
  logic             w_retire;
  logic             w_bad_op;
  logic             r_illegal;
  logic [CNT_W-1:0] r_count;

  // State, sticky illegal flag and retire counter all freeze while en=0.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= FETCH;
      r_illegal <= 1'b0;
      r_count   <= '0;
    end else if (en) begin
      r_state <= w_next;
      if (w_bad_op) r_illegal <= 1'b1;
      if (w_retire) r_count <= r_count + CNT_W'(1);
    end
  end

  always_comb begin
    w_next   = r_state;
    w_retire = 1'b0;
    w_bad_op = 1'b0;
    case (r_state)
      FETCH:  if (mem_ready) w_next = DECODE;
      DECODE: begin
        case (op)
          OP_LW, OP_SW: w_next = MEMADR;
          OP_R:         w_next = EXEC;
          OP_BEQ:       w_next = BRANCH;
          OP_J:         w_next = JUMP;
          OP_ADDI:      w_next = ADDIEX;
          default: begin
            w_next   = FETCH;
            w_bad_op = 1'b1;
          end
        endcase
      end
      MEMADR: w_next = (op == OP_SW) ? MEMWR : MEMRD;
      MEMRD:  if (mem_ready) w_next = MEMWB;
      MEMWR: begin
        if (mem_ready) begin
          w_next   = FETCH;
          w_retire = 1'b1;
        end
      end
      MEMWB, ALUWB, BRANCH, JUMP, ADDIWB: begin
        w_next   = FETCH;
        w_retire = 1'b1;
      end
      EXEC:    w_next = ALUWB;
      ADDIEX:  w_next = ADDIWB;
      default: w_next = FETCH;
    endcase
  end

  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    pc_src        = 2'b00;
    case (r_state)
      FETCH: begin
        mem_read  = 1'b1;
        ir_write  = mem_ready;
        alu_src_b = 2'b01;
        pc_write  = mem_ready;
      end
      DECODE: alu_src_b = 2'b11;
      MEMADR, ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      MEMRD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
      end
      MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      MEMWR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
      end
      EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
      end
      ALUWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'b01;
        pc_write_cond = 1'b1;
        pc_src        = 2'b01;
      end
      JUMP: begin
        pc_write = 1'b1;
        pc_src   = 2'b10;
      end
      ADDIWB:  reg_write = 1'b1;
      default: ;
    endcase
    // Stall suppresses only the write strobes; reset then clears everything.
    if (!en) begin
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      ir_write      = 1'b0;
      mem_write     = 1'b0;
      reg_write     = 1'b0;
    end
    if (rst) begin
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      iord          = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      mem_to_reg    = 1'b0;
      reg_dst       = 1'b0;
      reg_write     = 1'b0;
      alu_src_a     = 1'b0;
      alu_src_b     = 2'b00;
      alu_op        = 2'b00;
      pc_src        = 2'b00;
    end
  end

  assign state       = r_state;
  assign illegal     = r_illegal;
  assign instr_count = r_count;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: per-cycle expectations queued at drive time,
// popped and compared on the falling edge.
module tb_multicycle_ctrl;

  localparam logic [3:0] S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEMADR = 4'd2, S_MEMRD = 4'd3,
                         S_MEMWB = 4'd4, S_MEMWR = 4'd5, S_EXEC = 4'd6, S_ALUWB = 4'd7,
                         S_BRANCH = 4'd8, S_JUMP = 4'd9, S_ADDIEX = 4'd10, S_ADDIWB = 4'd11,
                         S_NONE = 4'd15;
  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011,
                         OP_BEQ = 6'b000100, OP_J = 6'b000010, OP_ADDI = 6'b001000,
                         OP_BAD = 6'b111111;

  logic        clk = 1'b0;
  logic        rst, en, mem_ready;
  logic [5:0]  op;
  logic        pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
  logic        mem_to_reg, reg_dst, reg_write, alu_src_a;
  logic [1:0]  alu_src_b, alu_op, pc_src;
  logic [3:0]  state;
  logic        illegal;
  logic [31:0] instr_count;

  multicycle_ctrl #(.CNT_W(32)) dut (
    .clk(clk), .rst(rst), .en(en), .mem_ready(mem_ready), .op(op),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .iord(iord),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_src(pc_src), .state(state), .illegal(illegal), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  st;
    logic [15:0] ctl;
    logic [31:0] cnt;
    logic        ill;
  } exp_t;

  exp_t        sb[$];
  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  logic [31:0] exp_cnt = '0;
  logic        exp_ill = 1'b0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Expected controls per state, written from the state table.
  // Order: pw pwc iord mrd mwr irw m2r rdst rw srca srcb[2] aluop[2] pcsrc[2]
  function automatic logic [15:0] exp_ctl(input logic [3:0] st, input logic e,
                                          input logic m, input logic r);
    logic pw, pwc, io, mrd, mwr, irw, m2r, rd, rw, sa;
    logic [1:0] sbv, ao, ps;
    {pw, pwc, io, mrd, mwr, irw, m2r, rd, rw, sa} = '0;
    sbv = 2'b00; ao = 2'b00; ps = 2'b00;
    case (st)
      S_FETCH:  begin mrd = 1'b1; irw = m; sbv = 2'b01; pw = m; end
      S_DECODE: sbv = 2'b11;
      S_MEMADR, S_ADDIEX: begin sa = 1'b1; sbv = 2'b10; end
      S_MEMRD:  begin mrd = 1'b1; io = 1'b1; end
      S_MEMWB:  begin rw = 1'b1; m2r = 1'b1; end
      S_MEMWR:  begin mwr = 1'b1; io = 1'b1; end
      S_EXEC:   begin sa = 1'b1; ao = 2'b10; end
      S_ALUWB:  begin rw = 1'b1; rd = 1'b1; end
      S_BRANCH: begin sa = 1'b1; ao = 2'b01; pwc = 1'b1; ps = 2'b01; end
      S_JUMP:   begin pw = 1'b1; ps = 2'b10; end
      S_ADDIWB: rw = 1'b1;
      default: ;
    endcase
    if (!e) {pw, pwc, irw, mwr, rw} = '0;
    if (r) return '0;
    return {pw, pwc, io, mrd, mwr, irw, m2r, rd, rw, sa, sbv, ao, ps};
  endfunction

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check_eq($sformatf("st%0d_state", e.st), 64'(state), 64'(e.st));
      check_eq($sformatf("st%0d_ctl", e.st),
               64'({pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
                    mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_src}),
               64'(e.ctl));
      check_eq($sformatf("st%0d_count", e.st), 64'(instr_count), 64'(e.cnt));
      check_eq($sformatf("st%0d_illegal", e.st), 64'(illegal), 64'(e.ill));
    end
  end

  task automatic cyc(input logic r, input logic e, input logic m, input logic [5:0] o,
                     input logic [3:0] st);
    exp_t x;
    @(posedge clk);
    #1;
    rst = r; en = e; mem_ready = m; op = o;
    x.st = st; x.ctl = exp_ctl(st, e, m, r); x.cnt = exp_cnt; x.ill = exp_ill;
    sb.push_back(x);
  endtask

  // One instruction from FETCH back to FETCH, with optional wait/stall cycles in one state.
  task automatic run_instr(input logic [5:0] o, input logic [3:0] wst, input int unsigned nw,
                           input logic [3:0] sst, input int unsigned ns);
    logic [3:0]  p[$];
    int unsigned kw, ks;
    bit          done;
    case (o)
      OP_LW:   p = '{S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB};
      OP_SW:   p = '{S_FETCH, S_DECODE, S_MEMADR, S_MEMWR};
      OP_R:    p = '{S_FETCH, S_DECODE, S_EXEC, S_ALUWB};
      OP_ADDI: p = '{S_FETCH, S_DECODE, S_ADDIEX, S_ADDIWB};
      OP_BEQ:  p = '{S_FETCH, S_DECODE, S_BRANCH};
      OP_J:    p = '{S_FETCH, S_DECODE, S_JUMP};
      default: p = '{S_FETCH, S_DECODE};
    endcase
    foreach (p[i]) begin
      kw = 0; ks = 0; done = 1'b0;
      while (!done) begin
        if (p[i] == sst && ks < ns) begin
          cyc(1'b0, 1'b0, 1'b1, o, p[i]); ks++;
        end else if (p[i] == wst && kw < nw) begin
          cyc(1'b0, 1'b1, 1'b0, o, p[i]); kw++;
        end else begin
          cyc(1'b0, 1'b1, 1'b1, o, p[i]); done = 1'b1;
        end
      end
    end
    if (p.size() > 2) exp_cnt = exp_cnt + 32'd1;
    else exp_ill = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; en = 1'b1; mem_ready = 1'b1; op = OP_LW;
    cyc(1'b1, 1'b1, 1'b1, OP_LW, S_FETCH);
    cyc(1'b1, 1'b1, 1'b1, OP_LW, S_FETCH);
    run_instr(OP_LW, S_NONE, 0, S_NONE, 0);
    run_instr(OP_LW, S_MEMRD, 2, S_NONE, 0);
    run_instr(OP_R,    S_NONE, 0, S_NONE, 0);
    run_instr(OP_SW,   S_NONE, 0, S_NONE, 0);
    run_instr(OP_BEQ,  S_NONE, 0, S_NONE, 0);
    run_instr(OP_J,    S_NONE, 0, S_NONE, 0);
    run_instr(OP_ADDI, S_NONE, 0, S_NONE, 0);
    run_instr(OP_BAD,  S_NONE, 0, S_NONE, 0);
    run_instr(OP_R,    S_NONE, 0, S_NONE, 0);
    run_instr(OP_R,    S_NONE, 0, S_ALUWB, 3);
    run_instr(OP_SW,   S_FETCH, 1, S_NONE, 0);
    run_instr(OP_LW,   S_FETCH, 0, S_FETCH, 2);
    // sw abandoned by reset while in MEMWR
    cyc(1'b0, 1'b1, 1'b1, OP_SW, S_FETCH);
    cyc(1'b0, 1'b1, 1'b1, OP_SW, S_DECODE);
    cyc(1'b0, 1'b1, 1'b1, OP_SW, S_MEMADR);
    cyc(1'b0, 1'b1, 1'b0, OP_SW, S_MEMWR);
    cyc(1'b1, 1'b1, 1'b1, OP_SW, S_MEMWR);
    exp_cnt = '0;
    exp_ill = 1'b0;
    run_instr(OP_R, S_NONE, 0, S_NONE, 0);
    cyc(1'b0, 1'b1, 1'b0, OP_R, S_FETCH);
    @(negedge clk);
    #1;
    check_eq("sb_drain", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
